// File: rtl/clint_pkg.sv
// rtl/clint_pkg.sv - shared register map, response codes and helpers for the CLINT
package clint_pkg;

  localparam logic [15:0] MSIP_OFF     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {REG_NONE, REG_MSIP, REG_MTIMECMP, REG_MTIME} clint_reg_e;
  typedef enum logic [1:0] {WR_IDLE, WR_AW, WR_W, WR_RESP} wr_state_e;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;

  function automatic logic [63:0] strb_merge(input logic [63:0] old_val,
                                             input logic [63:0] new_val,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    for (int i = 0; i < 8; i++) begin
      res[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_timer.sv
// rtl/clint_timer.sv - prescaled mtime counter, mtimecmp register and timer interrupt
module clint_timer #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mtime_we,
  input  logic        mtimecmp_we,
  input  logic [63:0] wdata,
  input  logic [7:0]  wstrb,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        timer_intr
);
  import clint_pkg::*;

  localparam int unsigned PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(TICK_DIV - 1);

  logic [PS_W-1:0] prescaler;
  logic            tick;

  assign tick = (prescaler == PS_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler  <= '0;
      mtime      <= '0;
      mtimecmp   <= MTIMECMP_RST;
      timer_intr <= 1'b0;
    end else begin
      prescaler <= tick ? '0 : prescaler + PS_W'(1);
      // A bus write wins over the tick; unstrobed bytes keep the pre-tick value
      if (mtime_we) begin
        mtime <= strb_merge(mtime, wdata, wstrb);
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end
      if (mtimecmp_we) begin
        mtimecmp <= strb_merge(mtimecmp, wdata, wstrb);
      end
      timer_intr <= (mtime >= mtimecmp);
    end
  end

endmodule

// File: rtl/axi_clint.sv
// rtl/axi_clint.sv - single-beat AXI4 slave CLINT: msip, mtimecmp, mtime
module axi_clint #(
  parameter logic [31:0] BASE_MASK    = 32'h0000_FFFF,
  parameter int unsigned TICK_DIV     = 1,
  parameter logic [15:0] MSIP_OFF     = clint_pkg::MSIP_OFF,
  parameter logic [15:0] MTIMECMP_OFF = clint_pkg::MTIMECMP_OFF,
  parameter logic [15:0] MTIME_OFF    = clint_pkg::MTIME_OFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_awaddr,
  input  logic        s_wvalid,
  output logic        s_wready,
  input  logic [63:0] s_wdata,
  input  logic [7:0]  s_wstrb,
  input  logic        s_wlast,
  output logic        s_bvalid,
  input  logic        s_bready,
  output logic [1:0]  s_bresp,
  input  logic        s_arvalid,
  output logic        s_arready,
  input  logic [31:0] s_araddr,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [63:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rlast,
  output logic        timer_intr,
  output logic        sftwr_intr,
  output logic [63:0] mtime
);
  import clint_pkg::*;

  function automatic clint_reg_e decode(input logic [31:0] addr);
    logic [31:0] a;
    a = addr & BASE_MASK & ~32'h7;
    if (a == {16'h0, MSIP_OFF})     return REG_MSIP;
    if (a == {16'h0, MTIMECMP_OFF}) return REG_MTIMECMP;
    if (a == {16'h0, MTIME_OFF})    return REG_MTIME;
    return REG_NONE;
  endfunction

  wr_state_e   wr_state, wr_next;
  rd_state_e   rd_state, rd_next;
  logic        aw_held, w_held, aw_hs, w_hs, ar_hs, wr_commit;
  logic [31:0] awaddr_q, wr_addr;
  logic [63:0] wdata_q, wr_data, rd_data, mtimecmp;
  logic [7:0]  wstrb_q, wr_strb;
  clint_reg_e  wr_reg, rd_reg;
  logic        msip;
  logic        unused_wlast;

  assign unused_wlast = s_wlast;

  assign aw_held   = (wr_state == WR_AW);
  assign w_held    = (wr_state == WR_W);
  assign s_bvalid  = (wr_state == WR_RESP);
  assign s_awready = !aw_held && !s_bvalid;
  assign s_wready  = !w_held && !s_bvalid;
  assign aw_hs     = s_awvalid && s_awready;
  assign w_hs      = s_wvalid && s_wready;
  assign wr_commit = (aw_held || aw_hs) && (w_held || w_hs);
  assign wr_addr   = aw_held ? awaddr_q : s_awaddr;
  assign wr_data   = w_held ? wdata_q : s_wdata;
  assign wr_strb   = w_held ? wstrb_q : s_wstrb;
  assign wr_reg    = decode(wr_addr);

  always_ff @(posedge clk) begin
    if (reset) wr_state <= WR_IDLE;
    else       wr_state <= wr_next;
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE: begin
        if (wr_commit)  wr_next = WR_RESP;
        else if (aw_hs) wr_next = WR_AW;
        else if (w_hs)  wr_next = WR_W;
      end
      WR_AW, WR_W: if (wr_commit) wr_next = WR_RESP;
      WR_RESP:     if (s_bready)  wr_next = WR_IDLE;
      default:     wr_next = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      s_bresp  <= RESP_OKAY;
      msip     <= 1'b0;
    end else begin
      if (aw_hs) awaddr_q <= s_awaddr;
      if (w_hs) begin
        wdata_q <= s_wdata;
        wstrb_q <= s_wstrb;
      end
      if (wr_commit) s_bresp <= (wr_reg == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
      if (wr_commit && wr_reg == REG_MSIP && wr_strb[0]) msip <= wr_data[0];
    end
  end

  assign sftwr_intr = msip;

  clint_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .mtime_we   (wr_commit && wr_reg == REG_MTIME),
    .mtimecmp_we(wr_commit && wr_reg == REG_MTIMECMP),
    .wdata      (wr_data),
    .wstrb      (wr_strb),
    .mtime      (mtime),
    .mtimecmp   (mtimecmp),
    .timer_intr (timer_intr)
  );

  assign s_rvalid  = (rd_state == RD_RESP);
  assign s_rlast   = s_rvalid;
  assign s_arready = !s_rvalid;
  assign ar_hs     = s_arvalid && s_arready;
  assign rd_reg    = decode(s_araddr);

  always_ff @(posedge clk) begin
    if (reset) rd_state <= RD_IDLE;
    else       rd_state <= rd_next;
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (ar_hs)    rd_next = RD_RESP;
      RD_RESP: if (s_rready) rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  // Sampled from pre-edge register values so a same-edge write is not visible
  always_comb begin
    rd_data = '0;
    case (rd_reg)
      REG_MSIP:     rd_data = {63'd0, msip};
      REG_MTIMECMP: rd_data = mtimecmp;
      REG_MTIME:    rd_data = mtime;
      default:      rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_rdata <= '0;
      s_rresp <= RESP_OKAY;
    end else if (ar_hs) begin
      s_rdata <= rd_data;
      s_rresp <= (rd_reg == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
    end
  end

endmodule

// File: tb/tb_axi_clint.sv
// tb/tb_axi_clint.sv - self-checking bench for axi_clint
module tb_axi_clint;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_awvalid = 1'b0, s_awready;
  logic [31:0] s_awaddr = '0;
  logic        s_wvalid = 1'b0, s_wready;
  logic [63:0] s_wdata = '0;
  logic [7:0]  s_wstrb = '0;
  logic        s_wlast = 1'b1;
  logic        s_bvalid, s_bready = 1'b0;
  logic [1:0]  s_bresp;
  logic        s_arvalid = 1'b0, s_arready;
  logic [31:0] s_araddr = '0;
  logic        s_rvalid, s_rready = 1'b0;
  logic [63:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic        timer_intr, sftwr_intr;
  logic [63:0] mtime;

  always #5 clk = ~clk;

  axi_clint dut (
    .clk(clk), .reset(reset),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .timer_intr(timer_intr), .sftwr_intr(sftwr_intr), .mtime(mtime)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: mtime is an affine function of elapsed clock edges.
  logic [63:0] cyc = '0;
  logic        chk_en = 1'b0;
  logic        m_msip;
  logic [63:0] m_cmp, m_base, m_cyc;
  logic        exp_ti = 1'b0;

  function automatic logic [63:0] exp_mtime(input logic [63:0] c);
    return m_base + (c - m_cyc);
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n, input logic [7:0] s);
    logic [63:0] r;
    r = o;
    for (int b = 0; b < 8; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] region(input logic [31:0] a);
    return a & 32'h0000_FFF8;
  endfunction

  function automatic logic [1:0] model_resp(input logic [31:0] a);
    logic [31:0] r;
    r = region(a);
    return (r == 32'h0 || r == 32'h4000 || r == 32'hBFF8) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [63:0] model_rdata(input logic [31:0] a, input logic [63:0] c);
    case (region(a))
      32'h0000: return {63'd0, m_msip};
      32'h4000: return m_cmp;
      32'hBFF8: return exp_mtime(c);
      default:  return 64'd0;
    endcase
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s, input logic [63:0] c_pre);
    case (region(a))
      32'h0000: if (s[0]) m_msip = d[0];
      32'h4000: m_cmp = merge(m_cmp, d, s);
      32'hBFF8: begin
        m_base = merge(exp_mtime(c_pre), d, s);
        m_cyc  = c_pre + 64'd1;
      end
      default: ;
    endcase
  endtask

  task automatic model_reset;
    m_msip = 1'b0;
    m_cmp  = '1;
    m_base = '0;
    m_cyc  = '0;
  endtask

  always @(posedge clk) begin
    cyc    <= reset ? 64'd0 : cyc + 64'd1;
    exp_ti <= reset ? 1'b0 : (exp_mtime(cyc) >= m_cmp);
  end

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      check("mtime", mtime, exp_mtime(cyc));
      check("sftwr_intr", {63'd0, sftwr_intr}, {63'd0, m_msip});
      check("timer_intr", {63'd0, timer_intr}, {63'd0, exp_ti});
    end
  end

  task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                          input int bdelay, output logic [1:0] resp);
    logic [63:0] cpre;
    @(negedge clk);
    s_awvalid = 1'b1; s_awaddr = a;
    s_wvalid = 1'b1; s_wdata = d; s_wstrb = s;
    cpre = cyc;
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    check("bresp", {62'd0, s_bresp}, {62'd0, model_resp(a)});
    model_write(a, d, s, cpre);
    check("bvalid_set", {63'd0, s_bvalid}, 64'd1);
    resp = s_bresp;
    for (int i = 0; i < bdelay; i++) begin
      @(posedge clk); #1;
      check("bvalid_hold", {63'd0, s_bvalid}, 64'd1);
    end
    s_bready = 1'b1;
    @(posedge clk); #1;
    s_bready = 1'b0;
    check("bvalid_clear", {63'd0, s_bvalid}, 64'd0);
  endtask

  task automatic do_read(input logic [31:0] a, output logic [63:0] got, output logic [1:0] resp);
    logic [63:0] cpre;
    @(negedge clk);
    s_arvalid = 1'b1; s_araddr = a;
    cpre = cyc;
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    check("rvalid_set", {63'd0, s_rvalid}, 64'd1);
    check("rlast", {63'd0, s_rlast}, 64'd1);
    check("rresp", {62'd0, s_rresp}, {62'd0, model_resp(a)});
    check("rdata", s_rdata, model_rdata(a, cpre));
    got = s_rdata;
    resp = s_rresp;
    s_rready = 1'b1;
    @(posedge clk); #1;
    s_rready = 1'b0;
    check("rvalid_clear", {63'd0, s_rvalid}, 64'd0);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  strb;
    logic [1:0]  resp;
    logic [63:0] rdata;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    logic [63:0] got, cpre;
    logic [1:0]  resp;
    bit          found;

    tbl[0]  = '{1'b0, 32'h0000_4000, 64'h0, 8'h00, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[1]  = '{1'b1, 32'h0000_0000, 64'h1, 8'h0F, 2'b00, 64'h0};
    tbl[2]  = '{1'b0, 32'h0000_0000, 64'h0, 8'h00, 2'b00, 64'h1};
    tbl[3]  = '{1'b1, 32'h0000_0000, 64'h0, 8'h0F, 2'b00, 64'h0};
    tbl[4]  = '{1'b0, 32'h0000_0000, 64'h0, 8'h00, 2'b00, 64'h0};
    tbl[5]  = '{1'b1, 32'h0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hF0, 2'b00, 64'h0};
    tbl[6]  = '{1'b0, 32'h0000_0000, 64'h0, 8'h00, 2'b00, 64'h0};
    tbl[7]  = '{1'b1, 32'h0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01, 2'b00, 64'h0};
    tbl[8]  = '{1'b0, 32'h0000_0000, 64'h0, 8'h00, 2'b00, 64'h1};
    tbl[9]  = '{1'b1, 32'h0000_4000, 64'h1111_2222_3333_4444, 8'hFF, 2'b00, 64'h0};
    tbl[10] = '{1'b1, 32'h0000_4000, 64'hAAAA_BBBB_0000_0000, 8'hF0, 2'b00, 64'h0};
    tbl[11] = '{1'b0, 32'h0000_4000, 64'h0, 8'h00, 2'b00, 64'hAAAA_BBBB_3333_4444};
    tbl[12] = '{1'b0, 32'h0000_8000, 64'h0, 8'h00, 2'b10, 64'h0};
    tbl[13] = '{1'b1, 32'h0000_8000, 64'h5555_5555_5555_5555, 8'hFF, 2'b10, 64'h0};
    tbl[14] = '{1'b0, 32'hDEAD_4004, 64'h0, 8'h00, 2'b00, 64'hAAAA_BBBB_3333_4444};
    tbl[15] = '{1'b1, 32'h0000_4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'b00, 64'h0};
    tbl[16] = '{1'b1, 32'h0000_0000, 64'h0, 8'h01, 2'b00, 64'h0};

    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", {63'd0, s_awready}, 64'd1);
    check("rst_wready", {63'd0, s_wready}, 64'd1);
    check("rst_arready", {63'd0, s_arready}, 64'd1);
    check("rst_bvalid", {63'd0, s_bvalid}, 64'd0);
    check("rst_rvalid", {63'd0, s_rvalid}, 64'd0);
    check("rst_bresp", {62'd0, s_bresp}, 64'd0);
    check("rst_rresp", {62'd0, s_rresp}, 64'd0);
    check("rst_rdata", s_rdata, 64'd0);
    check("rst_timer_intr", {63'd0, timer_intr}, 64'd0);
    check("rst_sftwr_intr", {63'd0, sftwr_intr}, 64'd0);
    check("rst_mtime", mtime, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("mtime_after_5", mtime, 64'd5);

    // Vector table
    for (int i = 0; i < NV; i++) begin
      if (tbl[i].wr) begin
        do_write(tbl[i].addr, tbl[i].wdata, tbl[i].strb, i % 3, resp);
        check($sformatf("tbl%0d_bresp", i), {62'd0, resp}, {62'd0, tbl[i].resp});
      end else begin
        do_read(tbl[i].addr, got, resp);
        check($sformatf("tbl%0d_rresp", i), {62'd0, resp}, {62'd0, tbl[i].resp});
        check($sformatf("tbl%0d_rdata", i), got, tbl[i].rdata);
      end
    end

    // Timer compare: rises the cycle after mtime reaches mtimecmp
    do_write(32'hBFF8, 64'd0, 8'hFF, 0, resp);
    do_write(32'h4000, 64'd20, 8'hFF, 0, resp);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (timer_intr) found = 1'b1;
    end
    check("timer_rise_seen", {63'd0, found}, 64'd1);
    check("mtime_at_rise", mtime, 64'd21);

    // Raising mtimecmp clears timer_intr one cycle after the commit
    @(negedge clk);
    s_awvalid = 1'b1; s_awaddr = 32'h4000; s_wvalid = 1'b1; s_wdata = 64'd1000; s_wstrb = 8'hFF;
    cpre = cyc;
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    model_write(32'h4000, 64'd1000, 8'hFF, cpre);
    check("ti_at_commit", {63'd0, timer_intr}, 64'd1);
    s_bready = 1'b1;
    @(posedge clk); #1;
    s_bready = 1'b0;
    check("ti_after_commit", {63'd0, timer_intr}, 64'd0);
    check("bvalid_after_cmp", {63'd0, s_bvalid}, 64'd0);

    // AW three cycles before W, then bready withheld while new AW/W are offered
    @(negedge clk);
    s_awvalid = 1'b1; s_awaddr = 32'h0;
    @(posedge clk); #1;
    s_awvalid = 1'b0;
    check("aw_first_awready", {63'd0, s_awready}, 64'd0);
    check("aw_first_wready", {63'd0, s_wready}, 64'd1);
    repeat (2) begin
      @(posedge clk); #1;
      check("aw_wait_bvalid", {63'd0, s_bvalid}, 64'd0);
    end
    @(negedge clk);
    s_wvalid = 1'b1; s_wdata = 64'd1; s_wstrb = 8'h0F;
    cpre = cyc;
    @(posedge clk); #1;
    s_wvalid = 1'b0;
    model_write(32'h0, 64'd1, 8'h0F, cpre);
    check("aw_first_bvalid", {63'd0, s_bvalid}, 64'd1);
    check("aw_first_bresp", {62'd0, s_bresp}, 64'd0);
    s_awvalid = 1'b1; s_awaddr = 32'h0; s_wvalid = 1'b1; s_wdata = 64'd0; s_wstrb = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("stall_bvalid", {63'd0, s_bvalid}, 64'd1);
      check("stall_awready", {63'd0, s_awready}, 64'd0);
      check("stall_wready", {63'd0, s_wready}, 64'd0);
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    s_bready = 1'b1;
    @(posedge clk); #1;
    s_bready = 1'b0;
    check("stall_bvalid_clear", {63'd0, s_bvalid}, 64'd0);

    // W before AW: partial mtime write keeps the unincremented low byte
    @(negedge clk);
    s_wvalid = 1'b1; s_wdata = 64'h0000_0000_0000_0500; s_wstrb = 8'h02;
    @(posedge clk); #1;
    s_wvalid = 1'b0;
    check("w_first_wready", {63'd0, s_wready}, 64'd0);
    @(negedge clk);
    s_awvalid = 1'b1; s_awaddr = 32'hBFF8;
    cpre = cyc;
    @(posedge clk); #1;
    s_awvalid = 1'b0;
    model_write(32'hBFF8, 64'h500, 8'h02, cpre);
    check("w_first_bvalid", {63'd0, s_bvalid}, 64'd1);
    check("w_first_mtime", mtime, exp_mtime(cyc));
    s_bready = 1'b1;
    @(posedge clk); #1;
    s_bready = 1'b0;

    // Read and write of mtimecmp on the same edge: read sees the old value
    @(negedge clk);
    s_arvalid = 1'b1; s_araddr = 32'h4000;
    s_awvalid = 1'b1; s_awaddr = 32'h4000; s_wvalid = 1'b1; s_wdata = 64'd777; s_wstrb = 8'hFF;
    cpre = cyc;
    @(posedge clk); #1;
    s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
    check("rw_same_rdata", s_rdata, m_cmp);
    check("rw_same_old", s_rdata, 64'd1000);
    model_write(32'h4000, 64'd777, 8'hFF, cpre);
    s_rready = 1'b1; s_bready = 1'b1;
    @(posedge clk); #1;
    s_rready = 1'b0; s_bready = 1'b0;
    do_read(32'h4000, got, resp);
    check("rw_same_new", got, 64'd777);

    // Randomized traffic against the model
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      logic [63:0] d;
      logic [7:0]  s;
      int          k;
      k = $urandom_range(0, 3);
      case (k)
        0:       a = 32'h0;
        1:       a = 32'h4000;
        2:       a = 32'hBFF8;
        default: a = {16'h0, 1'b1, 15'($urandom)};
      endcase
      a = a | ($urandom & 32'hFFFF_0000) | $urandom_range(0, 7);
      d = {$urandom, $urandom};
      s = 8'($urandom);
      if ($urandom_range(0, 2) == 0) do_read(a, got, resp);
      else do_write(a, d, s, $urandom_range(0, 2), resp);
    end

    // Reset while a read response is outstanding
    @(negedge clk);
    s_arvalid = 1'b1; s_araddr = 32'h8000;
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    check("unmapped_rvalid", {63'd0, s_rvalid}, 64'd1);
    check("unmapped_rresp", {62'd0, s_rresp}, 64'd2);
    check("unmapped_rdata", s_rdata, 64'd0);
    chk_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    model_reset();
    check("reset_drops_rvalid", {63'd0, s_rvalid}, 64'd0);
    check("reset_arready", {63'd0, s_arready}, 64'd1);
    check("reset_mtime", mtime, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mtime_after_rereset", mtime, 64'd3);
    do_read(32'h4000, got, resp);
    check("cmp_after_rereset", got, 64'hFFFF_FFFF_FFFF_FFFF);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_clint.md
Name: axi_clint

Overview:
- Core-local interruptor for the single RV64 hart.
- An AXI4 single-beat slave on the CPU's cacheless data port (DP). It holds msip, mtimecmp and mtime.
- Drives the CPU's timer_intr and sftwr_intr inputs, and supplies the 64-bit time value for rdtime.
- Register map is SiFive-CLINT compatible, so standard firmware and Linux drivers work unchanged.

Parameters:
- BASE_MASK, 32'h0000_FFFF: address bits used for decode; bits outside the mask are ignored.
- TICK_DIV, 1: mtime increments once every TICK_DIV clk cycles; must be at least 1.
- MSIP_OFF, 16'h0000: offset of msip.
- MTIMECMP_OFF, 16'h4000: offset of mtimecmp.
- MTIME_OFF, 16'hBFF8: offset of mtime.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- s_awvalid  in  1  write address valid
- s_awready  out  1  write address ready
- s_awaddr  in  32  write address
- s_wvalid  in  1  write data valid
- s_wready  out  1  write data ready
- s_wdata  in  64  write data
- s_wstrb  in  8  byte strobes
- s_wlast  in  1  ignored; every transfer is single-beat
- s_bvalid  out  1  write response valid
- s_bready  in  1  write response ready
- s_bresp  out  2  write response
- s_arvalid  in  1  read address valid
- s_arready  out  1  read address ready
- s_araddr  in  32  read address
- s_rvalid  out  1  read data valid
- s_rready  in  1  read data ready
- s_rdata  out  64  read data
- s_rresp  out  2  read response
- s_rlast  out  1  equals s_rvalid
- timer_intr  out  1  machine timer interrupt
- sftwr_intr  out  1  machine software interrupt; equals msip[0]
- mtime  out  64  current mtime, connected to rdtime

Behaviour:
- Reset values:
  - msip=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, mtime=0, prescaler=0.
  - timer_intr=0, sftwr_intr=0.
  - s_bvalid=0, s_rvalid=0, s_bresp=0, s_rresp=0, s_rdata=0.
  - s_awready=1, s_wready=1, s_arready=1.
- Reset asserted mid-transaction drops any outstanding response.
- Decode:
  - Compare (addr & BASE_MASK) with addr[2:0] cleared against the three offsets.
  - Byte lanes are selected by wstrb; reads return the full 64-bit lane.
  - msip occupies lane bits [31:0]; only bit 0 is writable, the other bits read as 0.
  - Any other address is unmapped.
- Write channel:
  - Latch flags aw_held and w_held. AW and W may arrive in either order, or in the same cycle.
  - s_awready = !aw_held && !s_bvalid; s_wready = !w_held && !s_bvalid.
  - The write commits on the edge where both address and data are available (held or handshaking).
  - That same edge sets s_bvalid=1 and clears both flags.
  - s_bresp = 2'b00 (OKAY) if mapped, 2'b10 (SLVERR) if unmapped. Unmapped writes change no state.
  - s_bvalid holds until s_bready; no new AW or W is accepted while s_bvalid=1.
  - Minimum latency is AW+W handshake → s_bvalid on the next cycle.
- Read channel:
  - s_arready = !s_rvalid.
  - On the AR handshake, register the data from the pre-edge state, set s_rvalid=1 and s_rlast=1.
  - s_rresp = 2'b00 if mapped. If unmapped, s_rresp = 2'b10 and s_rdata=0.
  - Data and response hold until s_rready.
  - A read and a write to the same register on the same edge: the read returns the old value.
- Timer:
  - The prescaler counts 0..TICK_DIV-1; on wrap, mtime increments by 1, modulo 2^64.
  - A bus write to mtime has priority over the increment in the same cycle; unstrobed bytes keep the current (unincremented) value.
  - timer_intr is registered: timer_intr <= (mtime >= mtimecmp), unsigned 64-bit compare on the current register values. The flag therefore lags the registers by one cycle.
  - timer_intr is level-sensitive and clears only when mtimecmp is raised above mtime.
- sftwr_intr is msip[0], combinational from the register, so it changes the cycle after the write commits.
- The read FSM and write FSM are independent and may be active simultaneously.

Decomposition:
- clint_pkg holds:
  - offset constants MSIP_OFF, MTIMECMP_OFF and MTIME_OFF;
  - response codes RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - the mtimecmp reset constant.
- One sub-module, clint_timer, contains:
  - the prescaler, the mtime register with strobed write port, and the mtimecmp register;
  - the registered compare producing timer_intr.
- axi_clint keeps the AXI FSMs, address decode and msip.

Test Plan:
- Release reset, hold 5 cycles → timer_intr=0, sftwr_intr=0, mtime=5; read MTIMECMP_OFF → 64'hFFFF_FFFF_FFFF_FFFF, rresp=0.
- Write msip with wdata=1, wstrb=8'h0F → bvalid the cycle after the handshake, bresp=0, sftwr_intr=1. Write wdata=0 → sftwr_intr=0.
- Write mtime=0, then write mtimecmp=20 with TICK_DIV=1 → timer_intr rises the cycle after mtime reaches 20. Write mtimecmp=1000 → timer_intr falls 1 cycle after the commit.
- Present AW 3 cycles before W, with s_bready held low for 4 cycles → s_awready drops after the AW handshake. bvalid stays high with no new AW or W accepted until the bready handshake.
- Write mtimecmp=64'h1111_2222_3333_4444, then wdata=64'hAAAA_BBBB_0000_0000 with wstrb=8'hF0 → readback 64'hAAAA_BBBB_3333_4444.
- Read 0x8000, then write 0x8000 → rresp=2'b10 with rdata=0, and bresp=2'b10 with no register changed. Reset asserted while rvalid=1 → rvalid=0 on the next cycle.
